// File: rtl/fifo_drain_adapter_if.sv
// rtl/fifo_drain_adapter_if.sv - FIFO read side plus output stream bundle for fifo_drain_adapter
//
// Purpose: groups the FIFO read-side signals, the valid/ready output stream,
// the flush request and the transfer counter into one bundle.
// master modport: the adapter (drives fifo_rd_en, m_data, m_valid, words_out).
// slave modport : the surroundings (drive fifo_dout, fifo_empty, m_ready, flush).
//   fifo_dout  - FIFO registered data_out (valid the cycle after a read)
//   fifo_empty - FIFO empty flag
//   fifo_rd_en - FIFO read enable (combinational)
//   m_data     - stream data, head of the output buffer
//   m_valid    - stream valid
//   m_ready    - stream ready from the consumer
//   flush      - synchronous discard of buffered and in-flight words
//   words_out  - completed stream handshakes, wraps
interface fifo_drain_adapter_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  flush;
  logic [CNT_WIDTH-1:0]  words_out;

  modport master (
    input  fifo_dout, fifo_empty, m_ready, flush,
    output fifo_rd_en, m_data, m_valid, words_out
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready, flush,
    input  fifo_rd_en, m_data, m_valid, words_out
  );
endinterface

// File: rtl/fifo_drain_adapter.sv
// rtl/fifo_drain_adapter.sv - converts a 1-cycle-latency FIFO read port into a valid/ready stream
//
// Purpose: drains a synchronous FIFO (registered data_out) into a valid/ready
// stream at up to one word per cycle using a 2-entry output buffer. A read is
// only issued when a buffer slot is guaranteed for the returning word, so the
// FIFO is never read while empty and no returning word is ever dropped.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - fifo_drain_adapter_if.master (FIFO read side, output stream,
//         flush request, words_out counter)
module fifo_drain_adapter #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input logic                  clk,
  input logic                  rst,
  fifo_drain_adapter_if.master bus
);

  logic [FIFO_WIDTH-1:0] buf_mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            buf_count;
  logic                  inflight;
  logic                  drop;
  logic [CNT_WIDTH-1:0]  words_out_q;

  logic [1:0]            occupancy;
  logic                  pop;
  logic                  push;
  logic                  rd_en;

  // A flush forces rd_en low, so no read can be in flight at the end of a
  // flush cycle; the drop flag can therefore never be set and is held at 0.
  assign drop = 1'b0;

  always_comb begin
    occupancy = buf_count + {1'b0, inflight};
    pop       = (buf_count != 2'd0) && !bus.flush && bus.m_ready;
    // The returning word is discarded during a flush instead of being written.
    push      = inflight && !drop && !bus.flush;
    // Read only when the word returning next cycle has a slot: either there
    // is free room now, or the buffer is full but a word leaves this cycle.
    rd_en     = !rst && !bus.flush && !bus.fifo_empty &&
                ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (buf_count != 2'd0) && !bus.flush;
  assign bus.m_data     = buf_mem[head];
  assign bus.words_out  = words_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_mem[0]  <= '0;
      buf_mem[1]  <= '0;
      head        <= 1'b0;
      tail        <= 1'b0;
      buf_count   <= 2'd0;
      inflight    <= 1'b0;
      words_out_q <= '0;
    end else begin
      inflight <= rd_en;
      if (bus.flush) begin
        // Empty the buffer by collapsing head onto tail; no pop occurs.
        buf_count <= 2'd0;
        head      <= tail;
      end else begin
        if (push) begin
          buf_mem[tail] <= bus.fifo_dout;
          tail          <= ~tail;
        end
        if (pop) begin
          head        <= ~head;
          words_out_q <= words_out_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_adapter.sv
// tb/tb_fifo_drain_adapter.sv - self-checking bench for fifo_drain_adapter
module tb_fifo_drain_adapter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  fifo_drain_adapter_if #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) f_if ();
  fifo_drain_adapter_if #(.FIFO_WIDTH(W), .CNT_WIDTH(4))  w_if ();

  fifo_drain_adapter #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(f_if.master)
  );
  fifo_drain_adapter #(.FIFO_WIDTH(W), .CNT_WIDTH(4)) u_wrap (
    .clk(clk), .rst(rst), .bus(w_if.master)
  );

  // FIFO model for the main instance: registered data_out, 1-cycle latency.
  logic [W-1:0] mem [256];
  logic [7:0]   wr_ptr = 8'd0;
  logic [7:0]   rd_ptr;
  assign f_if.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr         <= 8'd0;
      f_if.fifo_dout <= '0;
    end else if (f_if.fifo_rd_en && !f_if.fifo_empty) begin
      f_if.fifo_dout <= mem[rd_ptr];
      rd_ptr         <= rd_ptr + 8'd1;
    end
  end

  // Source for the counter-wrap instance: w_loaded words available.
  int w_loaded = 0;
  int w_taken;
  int w_hs = 0;
  assign w_if.fifo_empty = (w_loaded == w_taken);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_taken        <= 0;
      w_if.fifo_dout <= '0;
    end else if (w_if.fifo_rd_en && !w_if.fifo_empty) begin
      w_taken        <= w_taken + 1;
      w_if.fifo_dout <= 16'(w_taken);
    end
  end

  // Observer: collects delivered words and tracks words held by the adapter
  // (read from the FIFO but not yet delivered or flushed).
  logic [W-1:0] got[$];
  int rd_pulses   = 0;
  int underflows  = 0;
  int inv_bad     = 0;
  int outstanding = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (f_if.fifo_rd_en) begin
        rd_pulses++;
        if (f_if.fifo_empty) underflows++;
      end
      if (f_if.flush) begin
        outstanding = 0;
      end else begin
        if (f_if.m_valid && f_if.m_ready) begin
          got.push_back(f_if.m_data);
          outstanding--;
        end
        if (f_if.fifo_rd_en && !f_if.fifo_empty) outstanding++;
      end
      if (outstanding > 2 || outstanding < 0) inv_bad++;
      if (w_if.m_valid && w_if.m_ready) w_hs++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && got.size() < n; i++) tick();
    if (got.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] words [4];
    bit ok;
    f_if.m_ready = 1'b1;
    f_if.flush   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      words[i] = 16'($urandom);
      load(words[i]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (f_if.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", f_if.fifo_rd_en); end
      total++; if (f_if.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", f_if.m_valid); end
      total++; if (f_if.m_data !== 16'h0) begin bad++; $display("FAIL reset_m_data: got %h want 0000", f_if.m_data); end
      total++; if (f_if.words_out !== 16'h0) begin bad++; $display("FAIL reset_words_out: got %0d want 0", f_if.words_out); end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (f_if.fifo_rd_en !== 1'b1) begin bad++; $display("FAIL release_rd_en_c0: got %b want 1", f_if.fifo_rd_en); end
    tick();
    @(negedge clk);
    total++; if (f_if.m_valid !== 1'b0) begin bad++; $display("FAIL release_valid_c1: got %b want 0", f_if.m_valid); end
    tick();
    @(negedge clk);
    total++; if (f_if.m_valid !== 1'b1 || f_if.m_data !== words[0]) begin
      bad++; $display("FAIL release_valid_c2: got v=%b d=%h want v=1 d=%h", f_if.m_valid, f_if.m_data, words[0]);
    end
    tick();
    wait_got(4, 20, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL reset_drain_timeout: got %0d words want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== words[i]) begin bad++; $display("FAIL reset_drain_data[%0d]: got %h want %h", i, got[i], words[i]); end
    end
    total++; if (f_if.words_out !== 16'd4) begin bad++; $display("FAIL reset_drain_count: got %0d want 4", f_if.words_out); end
  endtask

  task automatic test_streaming();
    logic       rd [14];
    logic       vl [14];
    logic [W-1:0] dt [14];
    logic [15:0] base;
    tick();
    got.delete();
    underflows   = 0;
    base         = f_if.words_out;
    f_if.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) load(16'(i));
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      rd[c] = f_if.fifo_rd_en;
      vl[c] = f_if.m_valid;
      dt[c] = f_if.m_data;
      tick();
    end
    for (int c = 0; c < 14; c++) begin
      total++; if (rd[c] !== (c < 8)) begin bad++; $display("FAIL stream_rd_en[c%0d]: got %b want %b", c, rd[c], (c < 8)); end
      total++; if (vl[c] !== (c >= 2 && c < 10)) begin bad++; $display("FAIL stream_valid[c%0d]: got %b want %b", c, vl[c], (c >= 2 && c < 10)); end
      if (c >= 2 && c < 10) begin
        total++; if (dt[c] !== 16'(c - 1)) begin bad++; $display("FAIL stream_data[c%0d]: got %h want %h", c, dt[c], 16'(c - 1)); end
      end
    end
    total++; if (f_if.words_out !== 16'(base + 16'd8)) begin bad++; $display("FAIL stream_count: got %0d want %0d", f_if.words_out, base + 16'd8); end
    total++; if (underflows !== 0) begin bad++; $display("FAIL stream_underflow: got %0d want 0", underflows); end
  endtask

  task automatic test_backpressure();
    bit ok;
    got.delete();
    f_if.m_ready = 1'b0;
    tick();
    rd_pulses = 0;
    for (int i = 1; i <= 8; i++) load(16'(i));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        total++; if (f_if.m_valid !== 1'b1 || f_if.m_data !== 16'h0001) begin
          bad++; $display("FAIL bp_hold[c%0d]: got v=%b d=%h want v=1 d=0001", c, f_if.m_valid, f_if.m_data);
        end
      end
      tick();
    end
    total++; if (rd_pulses !== 2) begin bad++; $display("FAIL bp_rd_pulses: got %0d want 2", rd_pulses); end
    f_if.m_ready = 1'b1;
    wait_got(8, 30, ok);
    tick(); tick();
    total++; if (ok !== 1'b1 || got.size() !== 8) begin bad++; $display("FAIL bp_drain_len: got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total++; if (got[i] !== 16'(i + 1)) begin bad++; $display("FAIL bp_drain_data[%0d]: got %h want %h", i, got[i], 16'(i + 1)); end
    end
  endtask

  task automatic test_toggle_ready();
    logic [W-1:0] words [16];
    logic [15:0] base;
    tick();
    got.delete();
    inv_bad = 0;
    base    = f_if.words_out;
    for (int i = 0; i < 16; i++) begin
      words[i] = 16'($urandom);
      load(words[i]);
    end
    for (int c = 0; c < 100 && got.size() < 16; c++) begin
      f_if.m_ready = (c % 2 == 0);
      tick();
    end
    f_if.m_ready = 1'b1;
    tick();
    total++; if (got.size() !== 16) begin bad++; $display("FAIL toggle_len: got %0d want 16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      total++; if (got[i] !== words[i]) begin bad++; $display("FAIL toggle_data[%0d]: got %h want %h", i, got[i], words[i]); end
    end
    total++; if (f_if.words_out !== 16'(base + 16'd16)) begin bad++; $display("FAIL toggle_count: got %0d want %0d", f_if.words_out, base + 16'd16); end
    total++; if (inv_bad !== 0) begin bad++; $display("FAIL toggle_occupancy: got %0d violations want 0", inv_bad); end
  endtask

  task automatic test_flush();
    logic [W-1:0] words [8];
    logic [W-1:0] exp_q[$];
    logic [15:0] wo;
    int r, d;
    bit ok;
    // Flush with two words buffered and the consumer stalled.
    got.delete();
    f_if.m_ready = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      words[i] = 16'($urandom);
      load(words[i]);
    end
    for (int c = 0; c < 4; c++) tick();
    wo = f_if.words_out;
    f_if.flush = 1'b1;
    @(negedge clk);
    total++; if (f_if.m_valid !== 1'b0) begin bad++; $display("FAIL flush_valid_f: got %b want 0", f_if.m_valid); end
    tick();
    f_if.flush = 1'b0;
    @(negedge clk);
    total++; if (f_if.m_valid !== 1'b0) begin bad++; $display("FAIL flush_valid_f1: got %b want 0", f_if.m_valid); end
    total++; if (f_if.words_out !== wo) begin bad++; $display("FAIL flush_count: got %0d want %0d", f_if.words_out, wo); end
    tick();
    f_if.m_ready = 1'b1;
    wait_got(6, 40, ok);
    tick(); tick();
    total++; if (got.size() !== 6) begin bad++; $display("FAIL flush_a_len: got %0d want 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      total++; if (got[i] !== words[i + 2]) begin bad++; $display("FAIL flush_a_data[%0d]: got %h want %h", i, got[i], words[i + 2]); end
    end
    // Flush mid-stream: the buffered word and the in-flight word are lost;
    // delivery resumes with the first word not yet read from the FIFO.
    got.delete();
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      words[i] = 16'($urandom);
      load(words[i]);
    end
    for (int c = 0; c < 4; c++) tick();
    r = rd_pulses;
    d = got.size();
    f_if.flush = 1'b1;
    tick();
    f_if.flush = 1'b0;
    exp_q.delete();
    for (int i = 0; i < d; i++) exp_q.push_back(words[i]);
    for (int i = r; i < 8; i++) exp_q.push_back(words[i]);
    wait_got(exp_q.size(), 40, ok);
    tick(); tick();
    total++; if (got.size() !== exp_q.size()) begin bad++; $display("FAIL flush_b_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL flush_b_data[%0d]: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] words [40];
    int loaded = 0;
    int n;
    tick();
    got.delete();
    underflows = 0;
    inv_bad    = 0;
    for (int i = 0; i < 40; i++) words[i] = 16'($urandom);
    for (int c = 0; c < 400 && got.size() < 40; c++) begin
      f_if.m_ready = ($urandom_range(0, 3) != 0);
      if (loaded < 40 && $urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n && loaded < 40; k++) begin
          load(words[loaded]);
          loaded++;
        end
      end
      tick();
    end
    f_if.m_ready = 1'b1;
    tick();
    total++; if (got.size() !== 40) begin bad++; $display("FAIL random_len: got %0d want 40", got.size()); end
    for (int i = 0; i < 40 && i < got.size(); i++) begin
      total++; if (got[i] !== words[i]) begin bad++; $display("FAIL random_data[%0d]: got %h want %h", i, got[i], words[i]); end
    end
    total++; if (underflows !== 0) begin bad++; $display("FAIL random_underflow: got %0d want 0", underflows); end
    total++; if (inv_bad !== 0) begin bad++; $display("FAIL random_occupancy: got %0d violations want 0", inv_bad); end
  endtask

  task automatic test_counter_wrap();
    total++; if (w_if.words_out !== 4'd0) begin bad++; $display("FAIL wrap_initial: got %0d want 0", w_if.words_out); end
    w_hs     = 0;
    w_loaded = w_loaded + 17;
    for (int c = 0; c < 60 && w_hs < 17; c++) tick();
    tick(); tick(); tick();
    total++; if (w_hs !== 17) begin bad++; $display("FAIL wrap_handshakes: got %0d want 17", w_hs); end
    total++; if (w_if.words_out !== 4'd1) begin bad++; $display("FAIL wrap_count: got %0d want 1", w_if.words_out); end
  endtask

  initial begin
    f_if.m_ready = 1'b1;
    f_if.flush   = 1'b0;
    w_if.m_ready = 1'b1;
    w_if.flush   = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_toggle_ready();
    test_flush();
    test_random();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_drain_adapter.md
Name: fifo_drain_adapter

Overview:
- Sits directly downstream of the team's synchronous FIFO (registered data_out, 1-cycle read latency).
- Converts the FIFO's rd_en/empty read side into a valid/ready stream for the next consumer.
- Issues rd_en only when it can guarantee space for the returning word, so the FIFO never sees a read while empty (no underflow) and no word is lost.
- Sustains one word per cycle through a 2-entry output buffer; also provides a synchronous flush and a transferred-word counter.

Parameters:
- FIFO_WIDTH, 16, data word width (matches the FIFO).
- CNT_WIDTH, 16, width of words_out counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, asynchronous and active-high.
- fifo_dout  in  FIFO_WIDTH  FIFO data_out; valid the cycle after a rd_en issued while non-empty.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable; combinational.
- m_data  out  FIFO_WIDTH  stream data = buffer head.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from consumer.
- flush  in  1  synchronous discard of buffered and in-flight words.
- words_out  out  CNT_WIDTH  count of completed stream handshakes; wraps modulo 2^CNT_WIDTH.

Behaviour:
- State:
  - 2-entry circular buffer with head/tail index and buf_count (0..2).
  - inflight flag: a read was issued last cycle and its data is on fifo_dout this cycle.
  - drop flag: the in-flight word must be discarded.
- Invariant: buf_count + inflight <= 2 in every cycle. The bench asserts it.
- Reset (rst=1, asynchronous): buf_count=0, inflight=0, drop=0, head/tail=0, m_data=0, m_valid=0, words_out=0. fifo_rd_en is forced 0 while rst=1.
- pop = m_valid && m_ready && !flush.
- fifo_rd_en = !rst && !flush && !fifo_empty && ((buf_count+inflight < 2) || (buf_count+inflight == 2 && pop)).
- Edge updates:
  - inflight <= fifo_rd_en.
  - If inflight && !drop: write fifo_dout at tail; tail++ (mod 2).
  - If pop: head++ (mod 2); words_out++.
  - buf_count <= buf_count + (inflight && !drop) - pop. A simultaneous push and pop leaves buf_count unchanged.
- Push into an empty buffer with a simultaneous pop is impossible, because m_valid=0 when the buffer is empty. There is no bypass path.
- m_valid = (buf_count != 0) && !flush. m_data = buffer[head], held stable while m_valid && !m_ready. Data order equals FIFO read order.
- Latency: rd_en in cycle N → fifo_dout valid in N+1 → captured at end of N+1 → m_valid in N+2. Minimum latency is 2 cycles from rd_en to m_valid.
- Throughput: 1 word/cycle steady state with m_ready held 1 (buf_count=1, inflight=1).
- Backpressure: with m_ready=0, at most 2 words are held. rd_en stays 0 once buf_count+inflight == 2.
- Flush (cycle F):
  - buf_count <= 0; head <= tail.
  - No pop, and words_out is unchanged.
  - fifo_rd_en = 0, so inflight <= 0.
  - An inflight word present in cycle F is discarded. drop is set only if inflight was set at the end of F, which cannot happen because rd_en=0. drop is therefore always 0 after flush and exists only as defensive state; it is tied to 0.
- fifo_empty rising while a read is in flight: no effect. The issued read completes normally.
- Combinational paths: fifo_rd_en depends on m_ready, flush and fifo_empty. The consumer must not drive m_ready from fifo_rd_en.
- Reset asserted mid-transfer: all state is cleared immediately. An in-flight word is lost, which is acceptable because the FIFO is reset by the same rst.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 with fifo_empty=0 and m_ready=1.
  - Required: fifo_rd_en=0, m_valid=0, m_data=0, words_out=0 throughout.
  - After release, the first rd_en appears in cycle 0 and m_valid in cycle 2.
- Streaming:
  - Stimulus: FIFO preloaded with 8 words 0x0001..0x0008, m_ready=1.
  - Required: rd_en high 8 consecutive cycles; m_data 0x0001..0x0008 on consecutive cycles, starting 2 cycles after the first rd_en; words_out=8.
  - Required: rd_en never asserted while fifo_empty=1, i.e. FIFO underflow stays 0.
- Backpressure:
  - Stimulus: 8 words available, m_ready=0.
  - Required: exactly 2 rd_en pulses, then rd_en=0; m_valid=1 with m_data=0x0001 held stable.
  - Stimulus: m_ready raised.
  - Required: words drain in order with no loss or duplication.
- Toggling ready:
  - Stimulus: m_ready alternating 1/0 over 16 words.
  - Required: all 16 words received in order; words_out=16; buf_count+inflight <= 2 every cycle.
- Flush:
  - Stimulus: flush pulsed for 1 cycle with buf_count=2 and m_ready=0.
  - Required: m_valid=0 in the flush cycle and the next; words_out unchanged.
  - Required: the next delivered word is the FIFO's next unread word; the 2 flushed words never appear.
- Counter wrap:
  - Stimulus: CNT_WIDTH=4, 17 words transferred.
  - Required: words_out=1.
